// File: rtl/address_window_map.sv
// Address window mapper: translates SNES bus addresses to PSRAM addresses through
// programmable windows with a built-in LoROM/SRAM fallback. Two-stage lookup pipeline,
// plus the snescmd unlock flag with a programmable release hold.
module address_window_map #(
    parameter int unsigned NUM_WIN     = 4,
    parameter int unsigned IDX_W       = 2,
    parameter int unsigned UNLOCK_HOLD = 16
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               cfg_we,
    input  logic [IDX_W-1:0]   cfg_idx,
    input  logic [1:0]         cfg_field,
    input  logic [23:0]        cfg_data,
    output logic               cfg_ack,
    input  logic [23:0]        SNES_ADDR,
    input  logic               addr_strobe,
    input  logic [23:0]        SAVERAM_MASK,
    input  logic [23:0]        ROM_MASK,
    input  logic               unlock_set,
    input  logic               unlock_clr,
    output logic [23:0]        ROM_ADDR,
    output logic               ROM_HIT,
    output logic               IS_ROM,
    output logic               IS_SAVERAM,
    output logic               IS_WRITABLE,
    output logic [NUM_WIN-1:0] win_hit,
    output logic               out_valid,
    output logic               snescmd_unlock
);

    localparam int unsigned CntW = $clog2(UNLOCK_HOLD + 1);

    typedef enum logic [1:0] {StIdle, StOpen, StRelease} unlock_state_e;

    // Shadow (staged) and active window configuration
    logic [23:0] sh_base [NUM_WIN];
    logic [23:0] sh_mask [NUM_WIN];
    logic [23:0] sh_off  [NUM_WIN];
    logic [23:0] act_base [NUM_WIN];
    logic [23:0] act_mask [NUM_WIN];
    logic [23:0] act_off  [NUM_WIN];
    logic [2:0]  act_ctrl [NUM_WIN];
    logic        idx_ok;

    // Stage 1 registers: address, match vector and the winner's translation fields
    logic               s1_valid;
    logic [23:0]        s1_addr;
    logic [NUM_WIN-1:0] s1_match;
    logic [23:0]        s1_off;
    logic [23:0]        s1_mask;
    logic [2:0]         s1_ctrl;
    logic               s1_unlock;

    logic [NUM_WIN-1:0] match;
    logic [23:0]        sel_off;
    logic [23:0]        sel_mask;
    logic [2:0]         sel_ctrl;

    logic [23:0]        n_addr;
    logic               n_rom;
    logic               n_sram;
    logic               n_wr;
    logic [NUM_WIN-1:0] n_win;
    logic               patch;
    logic               fb_sram;

    unlock_state_e  state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    assign idx_ok = (32'(cfg_idx) < NUM_WIN);

    // Config: field writes land in the shadow; a ctrl write commits the shadow atomically
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            cfg_ack <= 1'b0;
            for (int i = 0; i < int'(NUM_WIN); i++) begin
                sh_base[i]  <= '0;
                sh_mask[i]  <= '0;
                sh_off[i]   <= '0;
                act_base[i] <= '0;
                act_mask[i] <= '0;
                act_off[i]  <= '0;
                act_ctrl[i] <= '0;
            end
        end else begin
            cfg_ack <= cfg_we;
            if (cfg_we && idx_ok) begin
                unique case (cfg_field)
                    2'd0: sh_base[cfg_idx] <= cfg_data;
                    2'd1: sh_mask[cfg_idx] <= cfg_data;
                    2'd2: sh_off[cfg_idx]  <= cfg_data;
                    2'd3: begin
                        act_base[cfg_idx] <= sh_base[cfg_idx];
                        act_mask[cfg_idx] <= sh_mask[cfg_idx];
                        act_off[cfg_idx]  <= sh_off[cfg_idx];
                        act_ctrl[cfg_idx] <= cfg_data[2:0];
                    end
                    default: ;
                endcase
            end
        end
    end

    // Per-window match and lowest-index winner selection against the active set
    always_comb begin
        match    = '0;
        sel_off  = '0;
        sel_mask = '0;
        sel_ctrl = '0;
        for (int i = 0; i < int'(NUM_WIN); i++) begin
            match[i] = act_ctrl[i][0] && (((SNES_ADDR ^ act_base[i]) & act_mask[i]) == 24'h0);
        end
        for (int i = int'(NUM_WIN) - 1; i >= 0; i--) begin
            if (match[i]) begin
                sel_off  = act_off[i];
                sel_mask = act_mask[i];
                sel_ctrl = act_ctrl[i];
            end
        end
    end

    // Stage 1: capture the lookup so a later commit cannot disturb it
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            s1_valid  <= 1'b0;
            s1_addr   <= '0;
            s1_match  <= '0;
            s1_off    <= '0;
            s1_mask   <= '0;
            s1_ctrl   <= '0;
            s1_unlock <= 1'b0;
        end else begin
            s1_valid <= addr_strobe;
            if (addr_strobe) begin
                s1_addr   <= SNES_ADDR;
                s1_match  <= match;
                s1_off    <= sel_off;
                s1_mask   <= sel_mask;
                s1_ctrl   <= sel_ctrl;
                s1_unlock <= snescmd_unlock;
            end
        end
    end

    // Stage 2 translation: patch overrides windows, windows override the fallback map
    always_comb begin
        patch   = s1_unlock && (s1_addr[23:20] == 4'hF);
        fb_sram = !s1_unlock && (|SAVERAM_MASK) && !s1_addr[23] && (s1_addr[22:20] == 3'b111)
                  && !s1_addr[19] && !s1_addr[15];
        n_addr  = '0;
        n_rom   = 1'b0;
        n_sram  = 1'b0;
        n_wr    = 1'b0;
        n_win   = '0;
        if (patch) begin
            n_addr = s1_addr;
            n_wr   = 1'b1;
        end else if (|s1_match) begin
            n_addr = s1_off + (s1_addr & ~s1_mask);
            n_sram = s1_ctrl[2];
            n_wr   = s1_ctrl[1] | s1_ctrl[2];
            n_rom  = ~n_wr;
            n_win  = s1_match & (~s1_match + 1'b1);
        end else begin
            n_rom  = s1_addr[22] | s1_addr[15];
            n_sram = fb_sram;
            n_wr   = fb_sram;
            if (fb_sram) begin
                n_addr = 24'hE00000 | ({5'b0, s1_addr[19:16], s1_addr[14:0]} & SAVERAM_MASK);
            end else begin
                n_addr = {2'b00, s1_addr[22:16], s1_addr[14:0]} & ROM_MASK;
            end
        end
    end

    // Stage 2 output registers; hold last result while no lookup completes
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            out_valid   <= 1'b0;
            ROM_ADDR    <= '0;
            ROM_HIT     <= 1'b0;
            IS_ROM      <= 1'b0;
            IS_SAVERAM  <= 1'b0;
            IS_WRITABLE <= 1'b0;
            win_hit     <= '0;
        end else begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                ROM_ADDR    <= n_addr;
                ROM_HIT     <= n_rom | n_wr;
                IS_ROM      <= n_rom;
                IS_SAVERAM  <= n_sram;
                IS_WRITABLE <= n_wr;
                win_hit     <= n_win;
            end
        end
    end

    // Unlock FSM state register
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Unlock FSM next state; set beats clr, hold expires after UNLOCK_HOLD cycles
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (unlock_set) state_d = StOpen;
            end
            StOpen: begin
                if (!unlock_set && unlock_clr) begin
                    state_d = StRelease;
                    cnt_d   = CntW'(UNLOCK_HOLD);
                end
            end
            StRelease: begin
                if (unlock_set) begin
                    state_d = StOpen;
                    cnt_d   = '0;
                end else if (cnt_q <= CntW'(1)) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    assign snescmd_unlock = (state_q != StIdle);

endmodule

// File: tb/tb_address_window_map.sv
// Directed bench for address_window_map with hand-computed expectations.
module tb_address_window_map;

    localparam int unsigned NUM_WIN     = 4;
    localparam int unsigned IDX_W       = 2;
    localparam int unsigned UNLOCK_HOLD = 16;

    logic               CLK = 1'b0;
    logic               RST_N;
    logic               cfg_we;
    logic [IDX_W-1:0]   cfg_idx;
    logic [1:0]         cfg_field;
    logic [23:0]        cfg_data;
    logic               cfg_ack;
    logic [23:0]        SNES_ADDR;
    logic               addr_strobe;
    logic [23:0]        SAVERAM_MASK;
    logic [23:0]        ROM_MASK;
    logic               unlock_set;
    logic               unlock_clr;
    logic [23:0]        ROM_ADDR;
    logic               ROM_HIT;
    logic               IS_ROM;
    logic               IS_SAVERAM;
    logic               IS_WRITABLE;
    logic [NUM_WIN-1:0] win_hit;
    logic               out_valid;
    logic               snescmd_unlock;

    int checks   = 0;
    int failures = 0;

    address_window_map #(
        .NUM_WIN     (NUM_WIN),
        .IDX_W       (IDX_W),
        .UNLOCK_HOLD (UNLOCK_HOLD)
    ) dut (
        .CLK            (CLK),
        .RST_N          (RST_N),
        .cfg_we         (cfg_we),
        .cfg_idx        (cfg_idx),
        .cfg_field      (cfg_field),
        .cfg_data       (cfg_data),
        .cfg_ack        (cfg_ack),
        .SNES_ADDR      (SNES_ADDR),
        .addr_strobe    (addr_strobe),
        .SAVERAM_MASK   (SAVERAM_MASK),
        .ROM_MASK       (ROM_MASK),
        .unlock_set     (unlock_set),
        .unlock_clr     (unlock_clr),
        .ROM_ADDR       (ROM_ADDR),
        .ROM_HIT        (ROM_HIT),
        .IS_ROM         (IS_ROM),
        .IS_SAVERAM     (IS_SAVERAM),
        .IS_WRITABLE    (IS_WRITABLE),
        .win_hit        (win_hit),
        .out_valid      (out_valid),
        .snescmd_unlock (snescmd_unlock)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic cfg_write(input int idx, input logic [1:0] field, input logic [23:0] data);
        cfg_we    = 1'b1;
        cfg_idx   = IDX_W'(idx);
        cfg_field = field;
        cfg_data  = data;
        step();
        cfg_we = 1'b0;
        step();
    endtask

    // Strobe one address and leave outputs valid (sampled 2 edges after the strobe)
    task automatic lookup(input logic [23:0] addr);
        SNES_ADDR   = addr;
        addr_strobe = 1'b1;
        step();
        addr_strobe = 1'b0;
        step();
        check_eq("out_valid", 32'(out_valid), 32'd1);
    endtask

    task automatic pulse_set();
        unlock_set = 1'b1;
        step();
        unlock_set = 1'b0;
    endtask

    initial begin
        int hold;
        RST_N        = 1'b0;
        cfg_we       = 1'b0;
        cfg_idx      = '0;
        cfg_field    = '0;
        cfg_data     = '0;
        SNES_ADDR    = '0;
        addr_strobe  = 1'b0;
        SAVERAM_MASK = 24'h000000;
        ROM_MASK     = 24'hFFFFFF;
        unlock_set   = 1'b0;
        unlock_clr   = 1'b0;
        step();
        step();
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        check_eq("rst_addr", 32'(ROM_ADDR), 32'h0);
        check_eq("rst_unlock", 32'(snescmd_unlock), 32'd0);
        check_eq("rst_ack", 32'(cfg_ack), 32'd0);
        RST_N = 1'b1;
        step();

        // Fallback ROM, including the latency: not valid one edge after strobe
        SNES_ADDR   = 24'h008000;
        addr_strobe = 1'b1;
        step();
        addr_strobe = 1'b0;
        check_eq("lat1_valid", 32'(out_valid), 32'd0);
        step();
        check_eq("lat2_valid", 32'(out_valid), 32'd1);
        check_eq("rom_isrom", 32'(IS_ROM), 32'd1);
        check_eq("rom_addr", 32'(ROM_ADDR), 32'h000000);
        check_eq("rom_win", 32'(win_hit), 32'h0);
        step();
        check_eq("hold_valid", 32'(out_valid), 32'd0);
        check_eq("hold_isrom", 32'(IS_ROM), 32'd1);
        lookup(24'h3FFFFF);
        check_eq("rom2_addr", 32'(ROM_ADDR), 32'h1FFFFF);

        // Fallback SRAM
        SAVERAM_MASK = 24'h001FFF;
        lookup(24'h700123);
        check_eq("sram_is", 32'(IS_SAVERAM), 32'd1);
        check_eq("sram_addr", 32'(ROM_ADDR), 32'hE00123);
        check_eq("sram_wr", 32'(IS_WRITABLE), 32'd1);

        // Window 1 writable, window 2 read-only with wrapping offset
        cfg_write(1, 2'd0, 24'hC00000);
        check_eq("cfg_ack", 32'(cfg_ack), 32'd0);
        cfg_write(1, 2'd1, 24'hFF0000);
        cfg_write(1, 2'd2, 24'h400000);
        cfg_write(1, 2'd3, 24'h000003);
        lookup(24'hC01234);
        check_eq("w1_addr", 32'(ROM_ADDR), 32'h401234);
        check_eq("w1_win", 32'(win_hit), 32'h2);
        check_eq("w1_wr", 32'(IS_WRITABLE), 32'd1);
        check_eq("w1_rom", 32'(IS_ROM), 32'd0);
        check_eq("w1_hit", 32'(ROM_HIT), 32'd1);
        cfg_write(2, 2'd0, 24'h800000);
        cfg_write(2, 2'd1, 24'hF00000);
        cfg_write(2, 2'd2, 24'hF80000);
        cfg_write(2, 2'd3, 24'h000001);
        lookup(24'h8A0000);
        check_eq("w2_wrap", 32'(ROM_ADDR), 32'h020000);
        check_eq("w2_win", 32'(win_hit), 32'h4);
        check_eq("w2_rom", 32'(IS_ROM), 32'd1);

        // Window 0 on same range as window 1: lower index wins
        cfg_write(0, 2'd0, 24'hC00000);
        cfg_write(0, 2'd1, 24'hFF0000);
        cfg_write(0, 2'd2, 24'h000000);
        cfg_write(0, 2'd3, 24'h000005);
        lookup(24'hC01234);
        check_eq("prio_win", 32'(win_hit), 32'h1);
        check_eq("prio_addr", 32'(ROM_ADDR), 32'h001234);
        check_eq("prio_sram", 32'(IS_SAVERAM), 32'd1);

        // Shadow write only: mapping unchanged
        cfg_write(0, 2'd0, 24'hD00000);
        lookup(24'hC01234);
        check_eq("shadow_win", 32'(win_hit), 32'h1);

        // Commit on edge N with strobes at N and N+1
        cfg_we      = 1'b1;
        cfg_idx     = 2'd0;
        cfg_field   = 2'd3;
        cfg_data    = 24'h000001;
        SNES_ADDR   = 24'hC01234;
        addr_strobe = 1'b1;
        step();
        cfg_we = 1'b0;
        step();
        addr_strobe = 1'b0;
        check_eq("ord1_win", 32'(win_hit), 32'h1);
        check_eq("ord1_addr", 32'(ROM_ADDR), 32'h001234);
        step();
        check_eq("ord2_valid", 32'(out_valid), 32'd1);
        check_eq("ord2_win", 32'(win_hit), 32'h2);
        check_eq("ord2_addr", 32'(ROM_ADDR), 32'h401234);
        lookup(24'hD05678);
        check_eq("new_win", 32'(win_hit), 32'h1);
        check_eq("new_addr", 32'(ROM_ADDR), 32'h005678);
        check_eq("new_rom", 32'(IS_ROM), 32'd1);

        // Disable window 2: falls back
        cfg_write(2, 2'd3, 24'h000000);
        lookup(24'h8A0000);
        check_eq("dis_win", 32'(win_hit), 32'h0);
        check_eq("dis_addr", 32'(ROM_ADDR), 32'h050000);
        check_eq("dis_rom", 32'(IS_ROM), 32'd0);

        // Unlock: clr in idle ignored
        unlock_clr = 1'b1;
        step();
        unlock_clr = 1'b0;
        check_eq("clr_idle", 32'(snescmd_unlock), 32'd0);
        pulse_set();
        check_eq("set_open", 32'(snescmd_unlock), 32'd1);
        lookup(24'hF01234);
        check_eq("patch_addr", 32'(ROM_ADDR), 32'hF01234);
        check_eq("patch_wr", 32'(IS_WRITABLE), 32'd1);
        check_eq("patch_win", 32'(win_hit), 32'h0);
        lookup(24'h700123);
        check_eq("unl_sram", 32'(IS_SAVERAM), 32'd0);
        check_eq("unl_addr", 32'(ROM_ADDR), 32'h380123);

        // Hold length after clr
        unlock_clr = 1'b1;
        step();
        unlock_clr = 1'b0;
        hold = 0;
        for (int i = 0; i < 100; i++) begin
            if (!snescmd_unlock) break;
            hold++;
            step();
        end
        check_eq("hold_len", 32'(hold), 32'(UNLOCK_HOLD));

        // set mid-hold keeps it high
        pulse_set();
        unlock_clr = 1'b1;
        step();
        unlock_clr = 1'b0;
        repeat (5) step();
        pulse_set();
        repeat (40) step();
        check_eq("midhold_set", 32'(snescmd_unlock), 32'd1);

        // set+clr together stays open
        unlock_set = 1'b1;
        unlock_clr = 1'b1;
        step();
        unlock_set = 1'b0;
        unlock_clr = 1'b0;
        repeat (40) step();
        check_eq("setclr", 32'(snescmd_unlock), 32'd1);

        // Reset one cycle after a strobe
        SNES_ADDR   = 24'hC01234;
        addr_strobe = 1'b1;
        step();
        addr_strobe = 1'b0;
        RST_N       = 1'b0;
        begin
            int seen = 0;
            for (int i = 0; i < 4; i++) begin
                step();
                if (out_valid) seen++;
            end
            check_eq("rstmid_valid", 32'(seen), 32'd0);
        end
        check_eq("rstmid_unlock", 32'(snescmd_unlock), 32'd0);
        RST_N = 1'b1;
        step();
        lookup(24'hC01234);
        check_eq("rstmid_win", 32'(win_hit), 32'h0);
        check_eq("rstmid_addr", 32'(ROM_ADDR), 32'h201234);
        check_eq("rstmid_rom", 32'(IS_ROM), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
